// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// command encodings, FSM states and opcode predicates.
package mdu_pkg;

    localparam logic [2:0] MDU_MULT  = 3'b000;
    localparam logic [2:0] MDU_MULTU = 3'b001;
    localparam logic [2:0] MDU_DIV   = 3'b010;
    localparam logic [2:0] MDU_DIVU  = 3'b011;
    localparam logic [2:0] MDU_MADD  = 3'b100;
    localparam logic [2:0] MDU_MADDU = 3'b101;
    localparam logic [2:0] MDU_MSUB  = 3'b110;
    localparam logic [2:0] MDU_MSUBU = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } mdu_state_t;

    function automatic logic is_div(input logic [2:0] op);
        return op[2:1] == 2'b01;
    endfunction

    function automatic logic is_signed(input logic [2:0] op);
        return ~op[0];
    endfunction

    function automatic logic is_acc(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic is_sub(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// Unsigned shift-add multiplier / restoring divider sharing one WIDTH+1-bit adder.
// result always shows the value one step ahead, so the last step can be consumed directly.
module mdu_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 load,
    input  logic                 step,
    input  logic                 div_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   result
);

    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic [WIDTH-1:0] opnd;
    logic             mode_r;

    logic [WIDTH:0]   add_x;
    logic [WIDTH:0]   add_y;
    logic             add_cin;
    logic [WIDTH+1:0] sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] nxt_hi;
    logic [WIDTH-1:0] nxt_lo;

    assign shifted = {hi_r, lo_r[WIDTH-1]};

    // Divide subtracts via inverted operand plus carry-in; carry-out means no borrow.
    always_comb begin
        add_x   = {1'b0, hi_r};
        add_y   = lo_r[0] ? {1'b0, opnd} : '0;
        add_cin = 1'b0;
        if (mode_r) begin
            add_x   = shifted;
            add_y   = ~{1'b0, opnd};
            add_cin = 1'b1;
        end
    end

    assign sum = {1'b0, add_x} + {1'b0, add_y} + (WIDTH+2)'(add_cin);

    always_comb begin
        nxt_hi = sum[WIDTH:1];
        nxt_lo = {sum[0], lo_r[WIDTH-1:1]};
        if (mode_r) begin
            nxt_hi = sum[WIDTH+1] ? sum[WIDTH-1:0] : shifted[WIDTH-1:0];
            nxt_lo = {lo_r[WIDTH-2:0], sum[WIDTH+1]};
        end
    end

    assign result = {nxt_hi, nxt_lo};

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            hi_r   <= '0;
            lo_r   <= '0;
            opnd   <= '0;
            mode_r <= 1'b0;
        end else if (load) begin
            hi_r   <= '0;
            lo_r   <= div_mode ? a : b;
            opnd   <= div_mode ? b : a;
            mode_r <= div_mode;
        end else if (step) begin
            hi_r   <= nxt_hi;
            lo_r   <= nxt_lo;
        end
    end

endmodule

// File: rtl/mdu_seq.sv
// Iterative multiply/divide unit with HI/LO registers, accumulate and mthi/mtlo writes.
//   state | meaning
//   IDLE  | accepts start or mthi/mtlo writes
//   RUN   | WIDTH iteration cycles; last cycle writes hi/lo and raises done
//   FIN   | done cycle, busy still high; returns to IDLE
module mdu_seq import mdu_pkg::*; #(
    parameter int WIDTH = 32
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic              whi,
    input  logic              wlo,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  hi,
    output logic [WIDTH-1:0]  lo
);

    localparam int CW = $clog2(WIDTH);

    mdu_state_t       state;
    logic [CW-1:0]    cnt;
    logic [2:0]       op_r;
    logic             sa_r;
    logic             sb_r;
    logic             b_zero_r;
    logic [WIDTH-1:0] a_r;

    logic             accept;
    logic             core_step;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [2*WIDTH-1:0] core_res;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] fin_val;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;

    assign accept    = (state == IDLE) && start;
    assign core_step = (state == RUN) && (cnt != '0);
    assign a_mag     = (is_signed(op) && a[WIDTH-1]) ? -a : a;
    assign b_mag     = (is_signed(op) && b[WIDTH-1]) ? -b : b;

    mdu_iter_core #(.WIDTH(WIDTH)) u_core (
        .clock    (clock),
        .resetn   (resetn),
        .load     (accept),
        .step     (core_step),
        .div_mode (is_div(op)),
        .a        (a_mag),
        .b        (b_mag),
        .result   (core_res)
    );

    // Sign fix-up on magnitudes; remainder follows the dividend's sign.
    always_comb begin
        prod = (sa_r ^ sb_r) ? -core_res : core_res;
        quot = (sa_r ^ sb_r) ? -core_res[WIDTH-1:0] : core_res[WIDTH-1:0];
        rem  = sa_r ? -core_res[2*WIDTH-1:WIDTH] : core_res[2*WIDTH-1:WIDTH];
        if (b_zero_r) begin
            quot = '1;
            rem  = a_r;
        end
        if (is_div(op_r))
            fin_val = {rem, quot};
        else if (is_acc(op_r))
            fin_val = is_sub(op_r) ? ({hi, lo} - prod) : ({hi, lo} + prod);
        else
            fin_val = prod;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            cnt      <= '0;
            op_r     <= MDU_MULT;
            sa_r     <= 1'b0;
            sb_r     <= 1'b0;
            b_zero_r <= 1'b0;
            a_r      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_r     <= op;
                        sa_r     <= is_signed(op) && a[WIDTH-1];
                        sb_r     <= is_signed(op) && b[WIDTH-1];
                        b_zero_r <= is_div(op) && (b == '0);
                        a_r      <= a;
                        cnt      <= CW'(WIDTH - 1);
                        busy     <= 1'b1;
                        state    <= RUN;
                    end else begin
                        if (whi) hi <= a;
                        if (wlo) lo <= a;
                    end
                end
                RUN: begin
                    if (cnt == '0) begin
                        hi    <= fin_val[2*WIDTH-1:WIDTH];
                        lo    <= fin_val[WIDTH-1:0];
                        done  <= 1'b1;
                        state <= FIN;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
